// File: rtl/cache_pkg.sv
// Shared types and defaults for the refill cache: FSM state encoding,
// default geometry and a width helper that never returns zero.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    FLUSH     = 2'd3
  } state_e;

  localparam int unsigned DefNumSets      = 4;
  localparam int unsigned DefAssociativity = 2;
  localparam int unsigned DefTagWidth     = 8;
  localparam int unsigned DefDataWidth    = 32;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Refill victim choice for one set: lowest-index invalid way if any,
// otherwise the set's round-robin pointer (use_ptr tells the caller to advance it).
module cache_victim_sel #(
  parameter int unsigned Associativity = 2,
  parameter int unsigned WayWidth      = 1
) (
  input  logic [Associativity-1:0] valid,
  input  logic [WayWidth-1:0]      ptr,
  output logic [WayWidth-1:0]      victim,
  output logic                     use_ptr
);

  always_comb begin
    victim  = ptr;
    use_ptr = 1'b1;
    // Descending scan so the lowest invalid index is the last one written.
    for (int i = int'(Associativity) - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim  = WayWidth'(i);
        use_ptr = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cache_refill.sv
// Set-associative read cache with valid/ready lookups, single outstanding
// refill from the next memory level, round-robin replacement and a per-set flush walk.
module cache_refill
  import cache_pkg::*;
#(
  parameter int unsigned NumSets       = DefNumSets,
  parameter int unsigned Associativity = DefAssociativity,
  parameter int unsigned TagWidth      = DefTagWidth,
  parameter int unsigned DataWidth     = DefDataWidth,
  localparam int unsigned SetWidth     = clog2_min1(NumSets),
  localparam int unsigned WayWidth     = clog2_min1(Associativity)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [SetWidth-1:0]  req_set_i,
  input  logic [TagWidth-1:0]  req_tag_i,
  output logic                 resp_valid_o,
  output logic                 resp_hit_o,
  output logic [DataWidth-1:0] resp_data_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [SetWidth-1:0]  mem_req_set_o,
  output logic [TagWidth-1:0]  mem_req_tag_o,
  input  logic                 mem_resp_valid_i,
  input  logic [DataWidth-1:0] mem_resp_data_i,
  input  logic                 flush_i,
  output logic                 flush_busy_o,
  output logic [1:0]           state_o
);

  localparam int unsigned IdxWidth = clog2_min1(NumSets * Associativity);
  localparam logic [1:0] S_IDLE      = IDLE;
  localparam logic [1:0] S_MISS_REQ  = MISS_REQ;
  localparam logic [1:0] S_MISS_WAIT = MISS_WAIT;
  localparam logic [1:0] S_FLUSH     = FLUSH;

  typedef struct packed {
    logic                valid;
    logic [TagWidth-1:0] tag;
  } block_info_t;

  block_info_t          info_q [NumSets][Associativity];
  logic [WayWidth-1:0]  ptr_q [NumSets];
  logic [DataWidth-1:0] data_mem [NumSets*Associativity];

  logic [1:0]           state_q;
  logic                 flush_pending_q;
  logic [SetWidth-1:0]  set_q, flush_set_q, req_set_eff;
  logic [TagWidth-1:0]  tag_q;
  logic                 resp_valid_q, resp_hit_q;
  logic [DataWidth-1:0] resp_data_q;

  logic                     hit;
  logic [WayWidth-1:0]      hit_way, victim_way;
  logic                     use_ptr, accept;
  logic [Associativity-1:0] valid_vec;

  function automatic logic [IdxWidth-1:0] data_idx(input logic [SetWidth-1:0] s,
                                                   input logic [WayWidth-1:0] w);
    return IdxWidth'(32'(s) * Associativity + 32'(w));
  endfunction

  assign req_set_eff = (NumSets == 1) ? '0 : req_set_i;

  // Handshake: a lookup is taken on a rising edge where req_valid_i and req_ready_o are
  // both high; mem_req_* holds stable from first assertion until mem_req_ready_i is seen.
  assign req_ready_o     = rst_ni && (state_q == S_IDLE) && !flush_pending_q && !flush_i;
  assign accept          = req_valid_i && req_ready_o;
  assign mem_req_valid_o = (state_q == S_MISS_REQ);
  assign mem_req_set_o   = set_q;
  assign mem_req_tag_o   = tag_q;
  assign flush_busy_o    = flush_pending_q || (state_q == S_FLUSH);
  assign resp_valid_o    = resp_valid_q;
  assign resp_hit_o      = resp_hit_q;
  assign resp_data_o     = resp_data_q;
  assign state_o         = state_q;

  // Later matches overwrite earlier ones, so the highest-index way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < int'(Associativity); w++) begin
      if (info_q[req_set_eff][w].valid && info_q[req_set_eff][w].tag == req_tag_i) begin
        hit     = 1'b1;
        hit_way = WayWidth'(w);
      end
    end
  end

  always_comb begin
    valid_vec = '0;
    for (int w = 0; w < int'(Associativity); w++) valid_vec[w] = info_q[set_q][w].valid;
  end

  cache_victim_sel #(
    .Associativity(Associativity),
    .WayWidth     (WayWidth)
  ) u_victim_sel (
    .valid  (valid_vec),
    .ptr    (ptr_q[set_q]),
    .victim (victim_way),
    .use_ptr(use_ptr)
  );

  always_ff @(posedge clk_i) begin
    if (state_q == S_MISS_WAIT && mem_resp_valid_i)
      data_mem[data_idx(set_q, victim_way)] <= mem_resp_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      flush_pending_q <= 1'b0;
      flush_set_q     <= '0;
      set_q           <= '0;
      tag_q           <= '0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_data_q     <= '0;
      for (int s = 0; s < int'(NumSets); s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < int'(Associativity); w++) info_q[s][w] <= '0;
      end
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (flush_pending_q || flush_i) begin
            state_q         <= S_FLUSH;
            flush_set_q     <= '0;
            flush_pending_q <= 1'b0;
          end else if (accept) begin
            set_q <= req_set_eff;
            tag_q <= req_tag_i;
            if (hit) begin
              resp_valid_q <= 1'b1;
              resp_hit_q   <= 1'b1;
              resp_data_q  <= data_mem[data_idx(req_set_eff, hit_way)];
            end else begin
              state_q <= S_MISS_REQ;
            end
          end
        end
        S_MISS_REQ: begin
          if (flush_i) flush_pending_q <= 1'b1;
          if (mem_req_ready_i) state_q <= S_MISS_WAIT;
        end
        S_MISS_WAIT: begin
          if (flush_i) flush_pending_q <= 1'b1;
          if (mem_resp_valid_i) begin
            info_q[set_q][victim_way] <= '{valid: 1'b1, tag: tag_q};
            if (use_ptr)
              ptr_q[set_q] <= (ptr_q[set_q] == WayWidth'(Associativity - 1)) ? '0
                                                                            : ptr_q[set_q] + 1'b1;
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b0;
            resp_data_q  <= mem_resp_data_i;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          // Flush walk: one set per cycle; flush_i arriving here is absorbed.
          ptr_q[flush_set_q] <= '0;
          for (int w = 0; w < int'(Associativity); w++) info_q[flush_set_q][w] <= '0;
          if (flush_set_q == SetWidth'(NumSets - 1)) state_q <= S_IDLE;
          else flush_set_q <= flush_set_q + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill.sv
// Randomized bench for cache_refill against a per-set array model of the cache contents.
module tb_cache_refill;
  localparam int NS = 4;
  localparam int NA = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_set = '0;
  logic [7:0]  req_tag = '0;
  logic        resp_valid, resp_hit;
  logic [31:0] resp_data;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [1:0]  mem_req_set;
  logic [7:0]  mem_req_tag;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        flush = 1'b0, flush_busy;
  logic [1:0]  state;

  int total = 0, bad = 0;

  // Reference model of the cache contents plus an expected-response queue.
  bit          m_valid[NS][NA];
  logic [7:0]  m_tag[NS][NA];
  logic [31:0] m_data[NS][NA];
  int          m_ptr[NS];
  logic [31:0] exp_q[$];

  cache_refill dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_set_i(req_set), .req_tag_i(req_tag),
    .resp_valid_o(resp_valid), .resp_hit_o(resp_hit), .resp_data_o(resp_data),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_set_o(mem_req_set), .mem_req_tag_o(mem_req_tag),
    .mem_resp_valid_i(mem_resp_valid), .mem_resp_data_i(mem_resp_data),
    .flush_i(flush), .flush_busy_o(flush_busy), .state_o(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    for (int s = 0; s < NS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < NA; w++) m_valid[s][w] = 0;
    end
  endfunction

  function automatic void model_lookup(input int s, input int t, output bit h, output logic [31:0] d);
    h = 0; d = '0;
    for (int w = 0; w < NA; w++)
      if (m_valid[s][w] && int'(m_tag[s][w]) == t) begin h = 1; d = m_data[s][w]; end
  endfunction

  function automatic void model_fill(input int s, input int t, input logic [31:0] d);
    int v = -1;
    for (int w = 0; w < NA; w++) if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) begin v = m_ptr[s]; m_ptr[s] = (m_ptr[s] + 1) % NA; end
    m_valid[s][v] = 1; m_tag[s][v] = 8'(t); m_data[s][v] = d;
  endfunction

  // Drives one lookup from a negedge; returns what was observed (no judging here).
  task automatic access(input int s, input int t, input logic [31:0] d, input int stall,
                        input bit flush_in_wait, input bit rst_in_wait,
                        output bit seen, output bit hit, output logic [31:0] data,
                        output bit missed, output int mset, output int mtag, output bit stable);
    int n;
    seen = 0; hit = 0; data = '0; missed = 0; mset = -1; mtag = -1; stable = 1;
    req_valid = 1'b1; req_set = 2'(s); req_tag = 8'(t);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(negedge clk);
    req_valid = 1'b0;
    if (resp_valid) begin seen = 1; hit = resp_hit; data = resp_data; return; end
    if (!mem_req_valid) return;
    missed = 1; mset = int'(mem_req_set); mtag = int'(mem_req_tag);
    for (int i = 0; i < stall; i++) begin
      mem_resp_valid = 1'($urandom_range(0, 1)); mem_resp_data = $urandom;
      @(negedge clk);
      if (!mem_req_valid || int'(mem_req_set) != mset || int'(mem_req_tag) != mtag || req_ready)
        stable = 0;
    end
    mem_resp_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    if (mem_req_valid) stable = 0;
    if (flush_in_wait) begin flush = 1'b1; @(negedge clk); flush = 1'b0; end
    if (rst_in_wait) begin #2 rst_n = 1'b0; #1 return; end
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_data = d;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    if (resp_valid) begin seen = 1; hit = resp_hit; data = resp_data; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    total++; if (resp_hit !== 1'b0) begin bad++; $display("FAIL reset_resp_hit got=%b want=0", resp_hit); end
    total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_req_valid got=%b want=0", mem_req_valid); end
    total++; if (mem_req_set !== 2'd0 || mem_req_tag !== 8'd0) begin bad++; $display("FAIL reset_mem_req_addr got=%h/%h want=0/0", mem_req_set, mem_req_tag); end
    total++; if (flush_busy !== 1'b0) begin bad++; $display("FAIL reset_flush_busy got=%b want=0", flush_busy); end
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    total++; if (req_ready !== 1'b1 || state !== 2'd0) begin bad++; $display("FAIL post_reset_idle ready=%b state=%0d want 1/0", req_ready, state); end
  endtask

  task automatic test_basic_miss_hit();
    bit seen, hit, missed, stable; logic [31:0] data; int ms, mt;
    access(1, 'h12, 32'hDEADBEEF, 0, 0, 0, seen, hit, data, missed, ms, mt, stable);
    total++; if (!missed || ms != 1 || mt != 'h12) begin bad++; $display("FAIL first_miss_memreq missed=%0b set=%0d tag=%h want 1/1/12", missed, ms, mt); end
    total++; if (!seen || hit !== 1'b0 || data !== 32'hDEADBEEF) begin bad++; $display("FAIL first_miss_resp seen=%0b hit=%b data=%h want 1/0/deadbeef", seen, hit, data); end
    model_fill(1, 'h12, 32'hDEADBEEF);
    access(1, 'h12, 32'h0, 0, 0, 0, seen, hit, data, missed, ms, mt, stable);
    total++; if (!seen || missed || hit !== 1'b1 || data !== 32'hDEADBEEF) begin bad++; $display("FAIL repeat_hit seen=%0b missed=%0b hit=%b data=%h want 1/0/1/deadbeef", seen, missed, hit, data); end
  endtask

  task automatic test_replacement();
    bit seen, hit, missed, stable, eh; logic [31:0] data, ed, nd; int ms, mt;
    int tags[7] = '{'hA0, 'hA1, 'hA2, 'hA3, 'hA0, 'hA3, 'hA2};
    for (int i = 0; i < 7; i++) begin
      nd = $urandom;
      model_lookup(2, tags[i], eh, ed);
      if (!eh) ed = nd;
      access(2, tags[i], nd, 0, 0, 0, seen, hit, data, missed, ms, mt, stable);
      total++;
      if (!seen || hit !== eh || data !== ed) begin
        bad++; $display("FAIL replace_%0d tag=%h seen=%0b hit=%b data=%h want hit=%b data=%h", i, tags[i], seen, hit, data, eh, ed);
      end
      if (!eh) model_fill(2, tags[i], nd);
    end
  endtask

  task automatic test_stall();
    bit seen, hit, missed, stable; logic [31:0] data; int ms, mt;
    access(0, 'h3C, 32'h0BAD_F00D, 5, 0, 0, seen, hit, data, missed, ms, mt, stable);
    total++; if (!missed || !stable) begin bad++; $display("FAIL stall_stable missed=%0b stable=%0b want 1/1", missed, stable); end
    total++; if (!seen || hit !== 1'b0 || data !== 32'h0BAD_F00D) begin bad++; $display("FAIL stall_resp seen=%0b hit=%b data=%h want 1/0/0badf00d", seen, hit, data); end
    model_fill(0, 'h3C, 32'h0BAD_F00D);
  endtask

  task automatic test_flush();
    bit seen, hit, missed, stable; logic [31:0] data; int ms, mt, busy_cnt; bit ready_seen;
    for (int s = 0; s < NS; s++) begin
      access(s, 'h40 + s, 32'(s) + 32'h100, 0, 0, 0, seen, hit, data, missed, ms, mt, stable);
      model_fill(s, 'h40 + s, 32'(s) + 32'h100);
    end
    flush = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_pulse_ready got=%b want=0", req_ready); end
    @(negedge clk);
    flush = 1'b0;
    busy_cnt = 0; ready_seen = 0;
    for (int i = 0; i < 20 && flush_busy; i++) begin
      busy_cnt++; if (req_ready) ready_seen = 1;
      @(negedge clk);
    end
    total++; if (busy_cnt != NS || ready_seen) begin bad++; $display("FAIL flush_busy_len got=%0d ready_seen=%0b want %0d/0", busy_cnt, ready_seen, NS); end
    model_clear();
    for (int s = 0; s < NS; s++) begin
      access(s, 'h40 + s, 32'hF0 + 32'(s), 0, 0, 0, seen, hit, data, missed, ms, mt, stable);
      total++; if (!missed || hit !== 1'b0) begin bad++; $display("FAIL post_flush_miss set=%0d missed=%0b hit=%b want 1/0", s, missed, hit); end
      model_fill(s, 'h40 + s, 32'hF0 + 32'(s));
    end
  endtask

  task automatic test_flush_during_miss();
    bit seen, hit, missed, stable; logic [31:0] data; int ms, mt, n;
    access(3, 'h77, 32'hCAFE_0077, 0, 1, 0, seen, hit, data, missed, ms, mt, stable);
    total++; if (!seen || hit !== 1'b0 || data !== 32'hCAFE_0077) begin bad++; $display("FAIL flush_in_miss_resp seen=%0b hit=%b data=%h want 1/0/cafe0077", seen, hit, data); end
    total++; if (flush_busy !== 1'b1 || state !== 2'd0) begin bad++; $display("FAIL flush_in_miss_pending busy=%b state=%0d want 1/0", flush_busy, state); end
    @(negedge clk);
    total++; if (state !== 2'd3) begin bad++; $display("FAIL flush_after_miss_state got=%0d want=3", state); end
    n = 0;
    while (flush_busy && n < 20) begin @(negedge clk); n++; end
    total++; if (flush_busy) begin bad++; $display("FAIL flush_after_miss_timeout busy=%b want=0", flush_busy); end
    model_clear();
  endtask

  task automatic test_random();
    bit seen, hit, missed, stable, eh; logic [31:0] data, ed, nd; int s, t, ms, mt, n;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        n = 0;
        while (flush_busy && n < 20) begin @(negedge clk); n++; end
        model_clear();
      end
      s = $urandom_range(0, NS - 1); t = 'h10 + $urandom_range(0, 4); nd = $urandom;
      model_lookup(s, t, eh, ed);
      exp_q.push_back(eh ? ed : nd);
      access(s, t, nd, $urandom_range(0, 2), 0, 0, seen, hit, data, missed, ms, mt, stable);
      ed = exp_q.pop_front();
      total++;
      if (!seen || hit !== eh || data !== ed || (missed && (ms != s || mt != t))) begin
        bad++; $display("FAIL random_%0d s=%0d t=%h seen=%0b hit=%b data=%h mem=%0d/%h want hit=%b data=%h", i, s, t, seen, hit, data, ms, mt, eh, ed);
      end
      if (!eh) model_fill(s, t, nd);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_miss();
    bit seen, hit, missed, stable; logic [31:0] data; int ms, mt; bit stale;
    access(3, 'h5A, 32'h1234_5678, 0, 0, 0, seen, hit, data, missed, ms, mt, stable);
    access(3, 'h5A, 32'h0, 0, 0, 0, seen, hit, data, missed, ms, mt, stable);
    total++; if (!seen || hit !== 1'b1 || data !== 32'h1234_5678) begin bad++; $display("FAIL pre_reset_hit seen=%0b hit=%b data=%h want 1/1/12345678", seen, hit, data); end
    access(3, 'h5B, 32'h0, 0, 0, 1, seen, hit, data, missed, ms, mt, stable);
    total++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_data !== 32'h0 ||
        mem_req_valid !== 1'b0 || mem_req_set !== 2'd0 || mem_req_tag !== 8'd0 || flush_busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_miss_outputs rdy=%b rv=%b rh=%b rd=%h mv=%b ms=%h mt=%h fb=%b want all 0",
                      req_ready, resp_valid, resp_hit, resp_data, mem_req_valid, mem_req_set, mem_req_tag, flush_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    stale = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (resp_valid) stale = 1; end
    total++; if (stale) begin bad++; $display("FAIL reset_stale_resp got=1 want=0"); end
    access(3, 'h5A, 32'h0000_AAAA, 0, 0, 0, seen, hit, data, missed, ms, mt, stable);
    total++; if (!missed || hit !== 1'b0 || data !== 32'h0000_AAAA) begin bad++; $display("FAIL post_reset_miss missed=%0b hit=%b data=%h want 1/0/0000aaaa", missed, hit, data); end
    model_fill(3, 'h5A, 32'h0000_AAAA);
  endtask

  initial begin
    test_reset();
    test_basic_miss_hit();
    test_replacement();
    test_stall();
    test_flush();
    test_flush_during_miss();
    test_random();
    test_reset_mid_miss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
